// File: rtl/aes128_key_expansion_ctrl_if.sv
// Control, read-port and write-stream bundle for aes128_key_expansion_ctrl.
// Key and round-key buses are [0:127] with bit 0 as the most significant bit.
interface aes128_key_expansion_ctrl_if #(
   parameter int unsigned IDX_W = 4
) ();
   logic             start;
   logic             abort;
   logic [0:127]     key_in;
   logic             busy;
   logic             done;
   logic             keys_valid;
   logic [IDX_W-1:0] rk_rd_idx;
   logic [0:127]     rk_rd_data;
   logic             rk_wr_valid;
   logic [IDX_W-1:0] rk_wr_idx;
   logic [0:127]     rk_wr_data;

   modport master (
      output start, abort, key_in, rk_rd_idx,
      input  busy, done, keys_valid, rk_rd_data, rk_wr_valid, rk_wr_idx, rk_wr_data
   );

   modport slave (
      input  start, abort, key_in, rk_rd_idx,
      output busy, done, keys_valid, rk_rd_data, rk_wr_valid, rk_wr_idx, rk_wr_data
   );
endinterface

// File: rtl/aes128_key_expansion_ctrl.sv
// AES-128 key expansion sequencer: one round per cycle into an 11-entry round-key bank.
// Optional KEY_EXP_ZEROIZE_EN clears the bank and working key on rst or abort.
module aes128_key_expansion_ctrl #(
   parameter int unsigned NUM_ROUNDS = 10,
   parameter int unsigned IDX_W      = 4
) (
   input logic                     clk,
   input logic                     rst,
   aes128_key_expansion_ctrl_if.slave bus
);

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StExpand = 2'd1;
   localparam logic [1:0] StReady  = 2'd2;

   localparam logic [IDX_W-1:0] LastRound = IDX_W'(NUM_ROUNDS);

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Inverse as a^254 (square-and-multiply), then the AES affine transform.
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] inv;
      sq  = gf_mul(a, a);
      inv = sq;
      for (int i = 0; i < 6; i++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
             {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [0:127] key_sched(input logic [0:127] k, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
      w0 = k[0:31];
      w1 = k[32:63];
      w2 = k[64:95];
      w3 = k[96:127];
      t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
      n0 = w0 ^ t;
      n1 = w1 ^ n0;
      n2 = w2 ^ n1;
      n3 = w3 ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   logic [1:0]       state_q, state_d;
   logic [IDX_W-1:0] round_q, round_d;
   logic [7:0]       rcon_q, rcon_d;
   logic [0:127]     cur_key_q, cur_key_d;
   logic             keys_valid_q, keys_valid_d;
   logic             done_q, done_d;
   logic             wr_valid_q, wr_valid_d;
   logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
   logic [0:127]     wr_data_q, wr_data_d;
   logic [0:127]     store_q [NUM_ROUNDS+1];
   logic             st_we;
   logic [IDX_W-1:0] st_idx;
   logic [0:127]     st_data;
   logic [0:127]     next_key;

   assign next_key = key_sched(cur_key_q, rcon_q);

   always_comb begin
      state_d      = state_q;
      round_d      = round_q;
      rcon_d       = rcon_q;
      cur_key_d    = cur_key_q;
      keys_valid_d = keys_valid_q;
      done_d       = 1'b0;
      wr_valid_d   = 1'b0;
      wr_idx_d     = wr_idx_q;
      wr_data_d    = wr_data_q;
      st_we        = 1'b0;
      st_idx       = '0;
      st_data      = '0;
      if (bus.abort) begin
         state_d      = StIdle;
         keys_valid_d = 1'b0;
         round_d      = '0;
         rcon_d       = 8'h01;
      end else begin
         case (state_q)
            StIdle, StReady: begin
               if (bus.start) begin
                  state_d      = StExpand;
                  cur_key_d    = bus.key_in;
                  round_d      = IDX_W'(1);
                  rcon_d       = 8'h01;
                  keys_valid_d = 1'b0;
                  st_we        = 1'b1;
                  st_data      = bus.key_in;
                  wr_valid_d   = 1'b1;
                  wr_idx_d     = '0;
                  wr_data_d    = bus.key_in;
               end
            end
            StExpand: begin
               cur_key_d  = next_key;
               rcon_d     = xtime(rcon_q);
               round_d    = round_q + IDX_W'(1);
               st_we      = 1'b1;
               st_idx     = round_q;
               st_data    = next_key;
               wr_valid_d = 1'b1;
               wr_idx_d   = round_q;
               wr_data_d  = next_key;
               if (round_q == LastRound) begin
                  state_d      = StReady;
                  done_d       = 1'b1;
                  keys_valid_d = 1'b1;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         round_q      <= '0;
         rcon_q       <= 8'h01;
         keys_valid_q <= 1'b0;
         done_q       <= 1'b0;
         wr_valid_q   <= 1'b0;
         wr_idx_q     <= '0;
         wr_data_q    <= '0;
      end else begin
         state_q      <= state_d;
         round_q      <= round_d;
         rcon_q       <= rcon_d;
         keys_valid_q <= keys_valid_d;
         done_q       <= done_d;
         wr_valid_q   <= wr_valid_d;
         wr_idx_q     <= wr_idx_d;
         wr_data_q    <= wr_data_d;
      end
   end

   // Key material lives outside the reset domain unless zeroization is built in.
   always_ff @(posedge clk) begin
`ifdef KEY_EXP_ZEROIZE_EN
      if (rst || bus.abort) begin
         cur_key_q <= '0;
         for (int unsigned i = 0; i < NUM_ROUNDS + 1; i++) store_q[i] <= '0;
      end else begin
`else
      if (!rst) begin
`endif
         cur_key_q <= cur_key_d;
         if (st_we) store_q[st_idx] <= st_data;
      end
   end

   assign bus.busy        = (state_q == StExpand);
   assign bus.done        = done_q;
   assign bus.keys_valid  = keys_valid_q;
   assign bus.rk_wr_valid = wr_valid_q;
   assign bus.rk_wr_idx   = wr_idx_q;
   assign bus.rk_wr_data  = wr_data_q;
   assign bus.rk_rd_data  = (bus.rk_rd_idx <= LastRound) ? store_q[bus.rk_rd_idx] : '0;

endmodule
